// File: rtl/axi_chk_pkg.sv
// axi_chk_pkg: shared widths, error codes and the error-priority helper for the AXI checker
package axi_chk_pkg;
  localparam int SIZE_WIDTH  = 3;
  localparam int BURST_WIDTH = 2;
  localparam int RESP_WIDTH  = 2;
  typedef enum logic [3:0] {
    ERR_NONE           = 4'd0,
    ERR_AW_UNSTABLE    = 4'd1,
    ERR_W_UNSTABLE     = 4'd2,
    ERR_AR_UNSTABLE    = 4'd3,
    ERR_B_UNSTABLE     = 4'd4,
    ERR_R_UNSTABLE     = 4'd5,
    ERR_RD_OVERFLOW    = 4'd6,
    ERR_R_UNEXPECTED   = 4'd7,
    ERR_RLAST_MISMATCH = 4'd8,
    ERR_RID_MISMATCH   = 4'd9,
    ERR_W_UNEXPECTED   = 4'd10,
    ERR_WLAST_MISMATCH = 4'd11,
    ERR_B_UNEXPECTED   = 4'd12,
    ERR_BID_MISMATCH   = 4'd13,
    ERR_TIMEOUT        = 4'd14,
    ERR_WR_OVERFLOW    = 4'd15
  } err_code_e;
  function automatic err_code_e lowest_code(input logic [15:0] errs);
    lowest_code = ERR_NONE;
    for (int i = 15; i >= 1; i--)
      if (errs[i]) lowest_code = err_code_e'(4'(i));
  endfunction
endpackage

// File: rtl/axi_chk_fifo.sv
// axi_chk_fifo: small tracking FIFO; a push into a full FIFO only lands when a pop frees a slot that cycle
module axi_chk_fifo
  import axi_chk_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  // next-state: pop only when occupied, push when a slot is free now or freed this cycle
  always_comb begin
    do_pop = pop && count_q != '0;
    do_push = push && (count_q != CW'(DEPTH) || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wptr_q] = din;
    wptr_d = do_push ? (wptr_q == PW'(DEPTH - 1) ? '0 : wptr_q + PW'(1)) : wptr_q;
    rptr_d = do_pop ? (rptr_q == PW'(DEPTH - 1) ? '0 : rptr_q + PW'(1)) : rptr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end
  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
  assign dout = mem_q[rptr_q];
  assign count = count_q;
endmodule

// File: rtl/axi_proto_checker.sv
// axi_proto_checker: passive AXI monitor for handshake stability, burst framing, id ordering and stalls
module axi_proto_checker
  import axi_chk_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    clear,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [LEN_WIDTH-1:0]    awlen,
  input  logic [SIZE_WIDTH-1:0]   awsize,
  input  logic [BURST_WIDTH-1:0]  awburst,
  input  logic                    awvalid,
  input  logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [RESP_WIDTH-1:0]   bresp,
  input  logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [LEN_WIDTH-1:0]    arlen,
  input  logic [SIZE_WIDTH-1:0]   arsize,
  input  logic [BURST_WIDTH-1:0]  arburst,
  input  logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [RESP_WIDTH-1:0]   rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  input  logic                    rready,
  output logic                    err_valid,
  output logic [3:0]              err_code,
  output logic [15:0]             err_sticky,
  output logic [CW-1:0]           rd_outstanding,
  output logic [CW-1:0]           wr_outstanding,
  output logic [15:0]             rd_txn_cnt,
  output logic [15:0]             wr_txn_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int QW = ID_WIDTH + LEN_WIDTH;
  localparam int APW = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + SIZE_WIDTH + BURST_WIDTH;
  localparam int WPW = DATA_WIDTH + DATA_WIDTH / 8 + 1;
  localparam int BPW = ID_WIDTH + RESP_WIDTH;
  localparam int RPW = ID_WIDTH + DATA_WIDTH + RESP_WIDTH + 1;
  logic [APW-1:0] aw_pl, aw_pl_q, ar_pl, ar_pl_q;
  logic [WPW-1:0] w_pl, w_pl_q;
  logic [BPW-1:0] b_pl, b_pl_q;
  logic [RPW-1:0] r_pl, r_pl_q;
  logic [4:0] vld, rdy, stall, stall_q, chg;
  logic [TW-1:0] to_q [5];
  logic [TW-1:0] to_d [5];
  logic tmo;
  logic [LEN_WIDTH-1:0] rbeat_q, rbeat_d, wbeat_q, wbeat_d;
  logic [QW-1:0] rf_dout, wf_dout;
  logic [ID_WIDTH-1:0] bf_dout, w_id;
  logic [LEN_WIDTH-1:0] w_len;
  logic [CW-1:0] rf_count, wf_count, bf_count;
  logic [CW:0] wr_sum;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic rf_empty, rf_full, wf_empty, wf_full, bf_empty;
  logic r_last_exp, w_last_exp, w_has_head, w_done;
  logic rf_pop, wf_push, wf_pop, bf_pop;
  logic [15:0] errs, err_sticky_q, err_sticky_d, rd_txn_q, rd_txn_d, wr_txn_q, wr_txn_d;
  logic err_valid_q;
  err_code_e err_code_q;
  assign aw_pl = {awid, awaddr, awlen, awsize, awburst};
  assign ar_pl = {arid, araddr, arlen, arsize, arburst};
  assign w_pl = {wdata, wstrb, wlast};
  assign b_pl = {bid, bresp};
  assign r_pl = {rid, rdata, rresp, rlast};
  assign vld = {rvalid, bvalid, arvalid, wvalid, awvalid};
  assign rdy = {rready, bready, arready, wready, awready};
  assign stall = vld & ~rdy;
  assign chg = {r_pl != r_pl_q, b_pl != b_pl_q, ar_pl != ar_pl_q, w_pl != w_pl_q, aw_pl != aw_pl_q};
  assign ar_hs = arvalid && arready;
  assign r_hs = rvalid && rready;
  assign aw_hs = awvalid && awready;
  assign w_hs = wvalid && wready;
  assign b_hs = bvalid && bready;
  assign rf_empty = rf_count == '0;
  assign rf_full = rf_count == CW'(MAX_OUTSTANDING);
  assign wf_empty = wf_count == '0;
  assign wf_full = wf_count == CW'(MAX_OUTSTANDING);
  assign bf_empty = bf_count == '0;
  // error detection and tracking state; a W beat alongside its AW on an empty write queue uses the AW directly
  always_comb begin
    tmo = 1'b0;
    for (int i = 0; i < 5; i++) begin
      to_d[i] = stall[i] ? (to_q[i] == TW'(TIMEOUT_CYCLES) ? to_q[i] : to_q[i] + TW'(1)) : '0;
      tmo = tmo | (stall[i] && to_q[i] == TW'(TIMEOUT_CYCLES - 1));
    end
    r_last_exp = rbeat_q == rf_dout[LEN_WIDTH-1:0];
    rf_pop = r_hs && !rf_empty && (rlast || r_last_exp);
    rbeat_d = rf_pop ? '0 : (r_hs && !rf_empty ? rbeat_q + LEN_WIDTH'(1) : rbeat_q);
    w_has_head = !wf_empty || aw_hs;
    w_id = wf_empty ? awid : wf_dout[QW-1:LEN_WIDTH];
    w_len = wf_empty ? awlen : wf_dout[LEN_WIDTH-1:0];
    w_last_exp = wbeat_q == w_len;
    w_done = w_hs && w_has_head && (wlast || w_last_exp);
    wf_pop = w_done && !wf_empty;
    wf_push = aw_hs && !(wf_empty && w_done);
    wbeat_d = w_done ? '0 : (w_hs && w_has_head ? wbeat_q + LEN_WIDTH'(1) : wbeat_q);
    bf_pop = b_hs && !bf_empty;
    errs = '0;
    errs[5:1] = stall_q & (~vld | chg);
    errs[6] = ar_hs && rf_full && !rf_pop;
    errs[7] = r_hs && rf_empty;
    errs[8] = r_hs && !rf_empty && (rlast != r_last_exp);
    errs[9] = r_hs && !rf_empty && rid != rf_dout[QW-1:LEN_WIDTH];
    errs[10] = w_hs && !w_has_head;
    errs[11] = w_hs && w_has_head && (wlast != w_last_exp);
    errs[12] = b_hs && bf_empty;
    errs[13] = b_hs && !bf_empty && bid != bf_dout;
    errs[14] = tmo;
    errs[15] = aw_hs && wf_full && !wf_pop;
    err_sticky_d = (clear ? '0 : err_sticky_q) | errs;
    rd_txn_d = clear ? '0 : (rf_pop && rd_txn_q != 16'hFFFF ? rd_txn_q + 16'd1 : rd_txn_q);
    wr_txn_d = clear ? '0 : (bf_pop && wr_txn_q != 16'hFFFF ? wr_txn_q + 16'd1 : wr_txn_q);
  end
  // observation registers and reported error state
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_pl_q <= '0;
      ar_pl_q <= '0;
      w_pl_q <= '0;
      b_pl_q <= '0;
      r_pl_q <= '0;
      stall_q <= '0;
      to_q <= '{default: '0};
      rbeat_q <= '0;
      wbeat_q <= '0;
      err_valid_q <= 1'b0;
      err_code_q <= ERR_NONE;
      err_sticky_q <= '0;
      rd_txn_q <= '0;
      wr_txn_q <= '0;
    end else begin
      aw_pl_q <= aw_pl;
      ar_pl_q <= ar_pl;
      w_pl_q <= w_pl;
      b_pl_q <= b_pl;
      r_pl_q <= r_pl;
      stall_q <= stall;
      to_q <= to_d;
      rbeat_q <= rbeat_d;
      wbeat_q <= wbeat_d;
      err_valid_q <= |errs;
      err_code_q <= lowest_code(errs);
      err_sticky_q <= err_sticky_d;
      rd_txn_q <= rd_txn_d;
      wr_txn_q <= wr_txn_d;
    end
  end
  axi_chk_fifo #(.WIDTH(QW), .DEPTH(MAX_OUTSTANDING)) u_rd_fifo (
    .clk(aclk), .rst_n(aresetn), .push(ar_hs), .pop(rf_pop),
    .din({arid, arlen}), .dout(rf_dout), .count(rf_count)
  );
  axi_chk_fifo #(.WIDTH(QW), .DEPTH(MAX_OUTSTANDING)) u_wr_fifo (
    .clk(aclk), .rst_n(aresetn), .push(wf_push), .pop(wf_pop),
    .din({awid, awlen}), .dout(wf_dout), .count(wf_count)
  );
  axi_chk_fifo #(.WIDTH(ID_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_b_fifo (
    .clk(aclk), .rst_n(aresetn), .push(w_done), .pop(bf_pop),
    .din(w_id), .dout(bf_dout), .count(bf_count)
  );
  assign wr_sum = {1'b0, wf_count} + {1'b0, bf_count};
  assign wr_outstanding = wr_sum[CW] ? '1 : wr_sum[CW-1:0];
  assign rd_outstanding = rf_count;
  assign err_valid = err_valid_q;
  assign err_code = err_code_q;
  assign err_sticky = err_sticky_q;
  assign rd_txn_cnt = rd_txn_q;
  assign wr_txn_cnt = wr_txn_q;
endmodule

// File: tb/tb_axi_proto_checker.sv
// tb_axi_proto_checker: directed scoreboard bench for the AXI protocol checker
module tb_axi_proto_checker;
  import axi_chk_pkg::*;
  localparam int CW = $clog2(4 + 1);
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic clear = 1'b0;
  logic [3:0] awid, arid, bid, rid, awlen, arlen;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [3:0] wstrb;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic err_valid;
  logic [3:0] err_code;
  logic [15:0] err_sticky, rd_txn_cnt, wr_txn_cnt;
  logic [CW-1:0] rd_outstanding, wr_outstanding;
  int n_tot = 0;
  int n_pass = 0;
  logic [3:0] exp_q[$];

  axi_proto_checker dut (
    .aclk(aclk), .aresetn(aresetn), .clear(clear),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .err_valid(err_valid), .err_code(err_code), .err_sticky(err_sticky),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .rd_txn_cnt(rd_txn_cnt), .wr_txn_cnt(wr_txn_cnt)
  );

  always #5 aclk = ~aclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    {awid, arid, bid, rid, awlen, arlen} = '0;
    {awaddr, araddr, wdata, rdata} = '0;
    {awsize, arsize, awburst, arburst, bresp, rresp, wstrb} = '0;
    {awvalid, awready, wlast, wvalid, wready, bvalid, bready} = '0;
    {arvalid, arready, rlast, rvalid, rready} = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step(input logic [3:0] code);
    logic [3:0] e;
    exp_q.push_back(code);
    @(posedge aclk);
    #1;
    e = exp_q.pop_front();
    chk("err_valid", 32'(err_valid), 32'(e != 4'd0));
    chk("err_code", 32'(err_code), 32'(e));
  endtask

  initial begin
    idle();
    #12;
    chk("rst_err_valid", 32'(err_valid), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_sticky", 32'(err_sticky), 0);
    chk("rst_rd_out", 32'(rd_outstanding), 0);
    chk("rst_wr_out", 32'(wr_outstanding), 0);
    chk("rst_rd_txn", 32'(rd_txn_cnt), 0);
    chk("rst_wr_txn", 32'(wr_txn_cnt), 0);
    aresetn = 1'b1;
    step(0);
    // read burst of two beats
    arvalid = 1; arready = 1; arid = 3; arlen = 1; step(0); idle();
    chk("rd_out_open", 32'(rd_outstanding), 1);
    rvalid = 1; rready = 1; rid = 3; rlast = 0; step(0);
    rlast = 1; step(0); idle();
    chk("rd_txn_after_burst", 32'(rd_txn_cnt), 1);
    chk("rd_out_closed", 32'(rd_outstanding), 0);
    // AW payload change while stalled
    awvalid = 1; awaddr = 32'h100; step(0);
    awaddr = 32'h104; step(1);
    chk("sticky_aw_unstable", 32'(err_sticky[1]), 1);
    awready = 1; step(0); idle();
    chk("wr_out_aw", 32'(wr_outstanding), 1);
    wvalid = 1; wready = 1; wlast = 1; step(0); idle();
    chk("wr_out_bpend", 32'(wr_outstanding), 1);
    bvalid = 1; bready = 1; bid = 0; step(0); idle();
    chk("wr_txn_first", 32'(wr_txn_cnt), 1);
    chk("wr_out_done", 32'(wr_outstanding), 0);
    clear = 1; step(0); clear = 0;
    chk("clear_sticky", 32'(err_sticky), 0);
    chk("clear_rd_txn", 32'(rd_txn_cnt), 0);
    chk("clear_wr_txn", 32'(wr_txn_cnt), 0);
    // read FIFO overflow on the fifth AR
    for (int i = 0; i < 5; i++) begin
      arvalid = 1; arready = 1; arid = 4'(i); arlen = 0;
      step(i == 4 ? 4'd6 : 4'd0);
    end
    idle();
    chk("rd_out_full", 32'(rd_outstanding), 4);
    chk("sticky_rd_ovf", 32'(err_sticky[6]), 1);
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rready = 1; rid = 4'(i); rlast = 1; step(0);
    end
    idle();
    chk("rd_out_drained", 32'(rd_outstanding), 0);
    chk("rd_txn_drained", 32'(rd_txn_cnt), 4);
    // early rlast pops, then the next beat is unexpected
    arvalid = 1; arready = 1; arid = 2; arlen = 3; step(0); idle();
    rvalid = 1; rready = 1; rid = 2; rlast = 1; step(8);
    chk("rd_out_early_pop", 32'(rd_outstanding), 0);
    step(7); idle();
    chk("rd_txn_early", 32'(rd_txn_cnt), 5);
    // two errors in one beat: id and rlast both wrong
    arvalid = 1; arready = 1; arid = 1; arlen = 0; step(0); idle();
    rvalid = 1; rready = 1; rid = 4; rlast = 0; step(8); idle();
    chk("sticky_rid_mm", 32'(err_sticky[9]), 1);
    chk("rd_out_multi", 32'(rd_outstanding), 0);
    // AW and single-beat W together, then wrong B id
    awvalid = 1; awready = 1; awid = 5; awlen = 0;
    wvalid = 1; wready = 1; wlast = 1; step(0); idle();
    chk("wr_out_same_cycle", 32'(wr_outstanding), 1);
    bvalid = 1; bready = 1; bid = 6; step(13); idle();
    chk("wr_txn_bid_mm", 32'(wr_txn_cnt), 1);
    chk("wr_out_bid_mm", 32'(wr_outstanding), 0);
    wvalid = 1; wready = 1; wlast = 1; step(10); idle();
    bvalid = 1; bready = 1; step(12); idle();
    // early wlast on a two-beat write
    awvalid = 1; awready = 1; awid = 1; awlen = 1; step(0); idle();
    wvalid = 1; wready = 1; wlast = 1; step(11); idle();
    chk("wr_out_wlast", 32'(wr_outstanding), 1);
    bvalid = 1; bready = 1; bid = 1; step(0); idle();
    chk("wr_txn_wlast", 32'(wr_txn_cnt), 2);
    // AR stall timeout fires once
    clear = 1; step(0); clear = 0;
    arvalid = 1; arid = 7;
    for (int i = 0; i < 300; i++) step(i == 255 ? 4'd14 : 4'd0);
    arready = 1; step(0); idle();
    chk("sticky_timeout", 32'(err_sticky[14]), 1);
    chk("rd_out_after_stall", 32'(rd_outstanding), 1);
    rvalid = 1; rready = 1; rid = 7; rlast = 1; step(0); idle();
    clear = 1; step(0); clear = 0;
    chk("clear_after_timeout", 32'(err_sticky), 0);
    // reset in the middle of a read burst
    arvalid = 1; arready = 1; arid = 2; arlen = 1; step(0); idle();
    rvalid = 1; rready = 1; rid = 2; rlast = 0; step(0); idle();
    chk("rd_out_pre_reset", 32'(rd_outstanding), 1);
    #2 aresetn = 0;
    #1 chk("rd_out_in_reset", 32'(rd_outstanding), 0);
    #1 aresetn = 1;
    rvalid = 1; rready = 1; rid = 2; rlast = 1; step(7); idle();
    step(0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/axi_proto_checker.md
AXI_PROTO_CHECKER -- requirements
Module: axi_proto_checker

Interface
REQ-001 Parameters SHALL be: ID_WIDTH 4, AXI ID width; ADDR_WIDTH 32, address width; DATA_WIDTH 32, data width; LEN_WIDTH 4, burst length width; MAX_OUTSTANDING 4, tracked transactions per direction (>=1); TIMEOUT_CYCLES 256, valid-without-ready limit (>=2).
REQ-002 Ports SHALL be: aclk in 1 clock; aresetn in 1 asynchronous active-low reset; clear in 1 synchronous clear of sticky errors and transaction counters.
REQ-003 AW inputs SHALL be awid ID_WIDTH, awaddr ADDR_WIDTH, awlen LEN_WIDTH, awsize 3, awburst 2, awvalid 1, awready 1; AR inputs are the same fields with the ar prefix.
REQ-004 W inputs SHALL be wdata DATA_WIDTH, wstrb DATA_WIDTH/8, wlast 1, wvalid 1, wready 1; B inputs bid ID_WIDTH, bresp 2, bvalid 1, bready 1.
REQ-005 R inputs SHALL be rid ID_WIDTH, rdata DATA_WIDTH, rresp 2, rlast 1, rvalid 1, rready 1.
REQ-006 Outputs SHALL be: err_valid out 1, one-cycle error pulse; err_code out 4, code of the reported error; err_sticky out 16, accumulated error bitmap (bit[n] = code n); rd_outstanding, wr_outstanding out $clog2(MAX_OUTSTANDING+1), open transactions; rd_txn_cnt, wr_txn_cnt out 16, completed transactions.

Function
REQ-007 A channel handshake SHALL be valid&ready sampled at a rising aclk edge.
REQ-008 Stability: if valid=1 and ready=0 at edge t, valid=0 or any payload change at edge t+1 SHALL flag AW_UNSTABLE(1), W_UNSTABLE(2), AR_UNSTABLE(3), B_UNSTABLE(4) or R_UNSTABLE(5).
REQ-009 AR handshake SHALL push {arid, arlen} into the read FIFO; if the FIFO is full and no pop occurs that cycle, RD_OVERFLOW(6) SHALL be flagged and the entry dropped.
REQ-010 R handshake with the read FIFO empty SHALL flag R_UNEXPECTED(7); otherwise rid != head id SHALL flag RID_MISMATCH(9).
REQ-011 The read beat counter SHALL increment per R beat; rlast=1 SHALL be required exactly when beat == head len, otherwise RLAST_MISMATCH(8) is flagged.
REQ-012 The head entry SHALL pop on any R beat with rlast=1 or beat == head len; on pop the beat counter resets to 0 and rd_txn_cnt increments.
REQ-013 AW handshake SHALL push {awid, awlen} into the write FIFO; full without a same-cycle pop SHALL flag WR_OVERFLOW(15).
REQ-014 W handshake with the write FIFO empty SHALL flag W_UNEXPECTED(10); wlast misplacement SHALL flag WLAST_MISMATCH(11), with the same counting rule as REQ-011.
REQ-015 On write-burst completion the id SHALL move to a B-pending FIFO of depth MAX_OUTSTANDING.
REQ-016 B handshake with B-pending empty SHALL flag B_UNEXPECTED(12); bid != head SHALL flag BID_MISMATCH(13); each B pop increments wr_txn_cnt.
REQ-017 Any valid held high with ready low for TIMEOUT_CYCLES consecutive cycles SHALL flag TIMEOUT(14), once per stall.
REQ-018 Outstanding counts: rd_outstanding = read FIFO occupancy; wr_outstanding = write FIFO plus B-pending occupancy.
REQ-019 Simultaneous push and pop on a full FIFO SHALL be legal; on an empty FIFO, a push does not satisfy a same-cycle pop.
REQ-020 Multiple errors in one cycle SHALL set all their sticky bits; err_code reports the lowest code; err_valid asserts one cycle after the offending edge.
REQ-021 Transaction counters SHALL saturate at 16'hFFFF; clear SHALL zero err_sticky and txn counters only, not FIFOs.
REQ-022 Checks are pure observation; checker outputs SHALL NOT influence any AXI signal.

Reset
REQ-023 aresetn low SHALL asynchronously zero all FIFOs, beat counters, timeout counters, previous-cycle registers and all outputs.
REQ-024 The first edge after reset release SHALL perform no stability check, since the previous-cycle valid registers read 0.
REQ-025 Reset mid-burst SHALL discard all tracking; later R/W/B beats of that burst flag the *_UNEXPECTED codes.

Structure
REQ-026 The package axi_chk_pkg SHALL hold the err_code enum (0 NONE to 15) and the fixed widths SIZE_WIDTH 3, BURST_WIDTH 2, RESP_WIDTH 2.
REQ-027 The sub-module axi_chk_fifo (parametrised width/depth, occupancy output) SHALL be instantiated three times: read, write, B-pending.

Verification
REQ-028 AR id=3 len=1, then two R beats id=3 with rlast on the 2nd -> no error, rd_txn_cnt=1, rd_outstanding=0.
REQ-029 awvalid=1, awready=0, awaddr changes 0x100->0x104 next cycle -> err_code=1, err_sticky[1]=1.
REQ-030 MAX_OUTSTANDING=4: five ARs with no R -> err_code=6 on the 5th, rd_outstanding=4.
REQ-031 AR len=3, R with rlast on beat 1 -> err_code=8; FIFO pops; a following R -> err_code=7.
REQ-032 arvalid high, arready low for 256 cycles -> a single err_code=14 pulse; clear -> err_sticky=0.
REQ-033 AW id=5 len=0 with a same-cycle W wlast=1, then B bid=6 -> err_code=13, wr_txn_cnt=1.
